// File: rtl/hazard_forward_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl_if
// Brief    : ID-stage hazard/forwarding bus; HAZARD_PERF_EN adds stall counters
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_forward_ctrl_if #(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
    logic [FWD_STAGES-1:0]       stageEn;
    logic [FWD_STAGES-1:0]       stageLoad;
    logic [FWD_STAGES*REG_W-1:0] stageReg;
    logic [NUM_SRC*REG_W-1:0]    srcReg;
    logic [NUM_SRC-1:0]          srcUsed;
    logic                        mdStart;
    logic                        flushIn;
    logic [NUM_SRC*SEL_W-1:0]    fwdSel;
    logic                        pcWrite;
    logic                        ifidWrite;
    logic                        idexWrite;
    logic                        bubbleID;
    logic                        bubbleEX;
    logic                        ifidFlush;
    logic                        mdBusy;
    logic                        mdDone;
`ifdef HAZARD_PERF_EN
    logic [31:0]                 loadStallCnt;
    logic [31:0]                 mdStallCnt;
`endif

    modport master (
        output stageEn, stageLoad, stageReg, srcReg, srcUsed, mdStart, flushIn,
        input  fwdSel, pcWrite, ifidWrite, idexWrite, bubbleID, bubbleEX,
               ifidFlush, mdBusy, mdDone
`ifdef HAZARD_PERF_EN
        , input loadStallCnt, mdStallCnt
`endif
    );

    modport slave (
        input  stageEn, stageLoad, stageReg, srcReg, srcUsed, mdStart, flushIn,
        output fwdSel, pcWrite, ifidWrite, idexWrite, bubbleID, bubbleEX,
               ifidFlush, mdBusy, mdDone
`ifdef HAZARD_PERF_EN
        , output loadStallCnt, mdStallCnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Brief    : Forwarding selects, load-use stall, mul/div stall sequencer and
//            flush gating. Optional macro HAZARD_PERF_EN adds stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int MD_LAT     = 4,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hazard_forward_ctrl_if.slave  bus
);
    localparam int               c_CNT_W   = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_MD_INIT = c_CNT_W'(MD_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [c_CNT_W-1:0]   r_mdCnt;
    logic [c_CNT_W-1:0]   w_nextCnt;
    logic [NUM_SRC-1:0]   w_srcHaz;
    logic                 w_loadHazard;
    logic                 w_pcWrite;
    logic                 w_ifidWrite;
    logic                 w_idexWrite;
    logic                 w_bubbleID;
    logic                 w_bubbleEX;
    logic                 w_ifidFlush;

    // Descending scan so the nearest (lowest-numbered) matching stage wins.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_W-1:0] w_src;
        logic [SEL_W-1:0] w_sel;
        logic             w_ldHit;

        assign w_src = bus.srcReg[i*REG_W +: REG_W];

        always_comb begin
            w_sel   = '0;
            w_ldHit = 1'b0;
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (bus.stageEn[k-1] && (w_src != '0) &&
                    (bus.stageReg[(k-1)*REG_W +: REG_W] == w_src)) begin
                    w_sel   = SEL_W'(k);
                    w_ldHit = bus.stageLoad[k-1] && (k <= LOAD_LAT);
                end
            end
        end

        assign bus.fwdSel[i*SEL_W +: SEL_W] = w_sel;
        assign w_srcHaz[i] = bus.srcUsed[i] && w_ldHit;
    end

    assign w_loadHazard = |w_srcHaz;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_mdCnt <= '0;
        end else begin
            r_state <= w_nextState;
            r_mdCnt <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_mdCnt;
        w_pcWrite   = 1'b1;
        w_ifidWrite = 1'b1;
        w_idexWrite = 1'b1;
        w_bubbleID  = 1'b0;
        w_bubbleEX  = 1'b0;
        w_ifidFlush = bus.flushIn;
        case (r_state)
            ST_RUN: begin
                if (bus.mdStart) begin
                    w_nextState = ST_MD_BUSY;
                    w_nextCnt   = c_MD_INIT;
                end
                if (w_loadHazard) begin
                    w_pcWrite   = 1'b0;
                    w_ifidWrite = 1'b0;
                    w_bubbleID  = 1'b1;
                    w_ifidFlush = 1'b0;
                end
            end
            ST_MD_BUSY: begin
                w_nextCnt = r_mdCnt - c_ONE;
                if (r_mdCnt == c_ONE) begin
                    w_nextState = ST_RUN;
                end
                w_pcWrite   = 1'b0;
                w_ifidWrite = 1'b0;
                w_idexWrite = 1'b0;
                w_bubbleEX  = 1'b1;
                w_ifidFlush = 1'b0;
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    assign bus.pcWrite   = w_pcWrite;
    assign bus.ifidWrite = w_ifidWrite;
    assign bus.idexWrite = w_idexWrite;
    assign bus.bubbleID  = w_bubbleID;
    assign bus.bubbleEX  = w_bubbleEX;
    assign bus.ifidFlush = w_ifidFlush;
    assign bus.mdBusy    = (r_state == ST_MD_BUSY);
    assign bus.mdDone    = (r_state == ST_MD_BUSY) && (r_mdCnt == c_ONE);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_loadStallCnt;
    logic [31:0] r_mdStallCnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_loadStallCnt <= '0;
            r_mdStallCnt   <= '0;
        end else begin
            if ((r_state == ST_RUN) && w_loadHazard && (r_loadStallCnt != 32'hFFFF_FFFF)) begin
                r_loadStallCnt <= r_loadStallCnt + 32'd1;
            end
            if ((r_state == ST_MD_BUSY) && (r_mdStallCnt != 32'hFFFF_FFFF)) begin
                r_mdStallCnt <= r_mdStallCnt + 32'd1;
            end
        end
    end

    assign bus.loadStallCnt = r_loadStallCnt;
    assign bus.mdStallCnt   = r_mdStallCnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_ctrl
// Brief    : Self-checking bench; two instances (LOAD_LAT 1 and 2) share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;
    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int FWD     = 3;
    localparam int SEL_W   = 2;
    localparam int MD_LAT  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic [FWD-1:0]        stageEn;
    logic [FWD-1:0]        stageLoad;
    logic [FWD*REG_W-1:0]  stageReg;
    logic [NUM_SRC*REG_W-1:0] srcReg;
    logic [NUM_SRC-1:0]    srcUsed;
    logic                  mdStart;
    logic                  flushIn;

    int tests    = 0;
    int fails    = 0;
    int mdRemain = 0;
`ifdef HAZARD_PERF_EN
    longint ldCntA = 0;
    longint ldCntB = 0;
    longint mdCntM = 0;
`endif

    hazard_forward_ctrl_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD), .SEL_W(SEL_W)) ifA ();
    hazard_forward_ctrl_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD), .SEL_W(SEL_W)) ifB ();

    assign ifA.stageEn = stageEn;   assign ifB.stageEn = stageEn;
    assign ifA.stageLoad = stageLoad; assign ifB.stageLoad = stageLoad;
    assign ifA.stageReg = stageReg; assign ifB.stageReg = stageReg;
    assign ifA.srcReg = srcReg;     assign ifB.srcReg = srcReg;
    assign ifA.srcUsed = srcUsed;   assign ifB.srcUsed = srcUsed;
    assign ifA.mdStart = mdStart;   assign ifB.mdStart = mdStart;
    assign ifA.flushIn = flushIn;   assign ifB.flushIn = flushIn;

    hazard_forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD),
                          .LOAD_LAT(1), .MD_LAT(MD_LAT), .SEL_W(SEL_W))
        dutA (.clk(clk), .reset_n(reset_n), .bus(ifA.slave));
    hazard_forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD),
                          .LOAD_LAT(2), .MD_LAT(MD_LAT), .SEL_W(SEL_W))
        dutB (.clk(clk), .reset_n(reset_n), .bus(ifB.slave));

    // Reference: nearest enabled stage whose destination equals a non-zero source.
    function automatic int refSel(int i);
        logic [REG_W-1:0] s;
        s = srcReg[i*REG_W +: REG_W];
        for (int k = 1; k <= FWD; k++) begin
            if (stageEn[k-1] && s != 0 && stageReg[(k-1)*REG_W +: REG_W] == s) return k;
        end
        return 0;
    endfunction

    function automatic bit refHaz(int lat);
        for (int i = 0; i < NUM_SRC; i++) begin
            int k;
            k = refSel(i);
            if (srcUsed[i] && k != 0 && k <= lat && stageLoad[k-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // {pcWrite, ifidWrite, idexWrite, bubbleID, bubbleEX, ifidFlush}
    function automatic logic [5:0] refCtl(int lat);
        if (mdRemain > 0) return 6'b000010;
        if (refHaz(lat))  return 6'b001100;
        return {5'b11100, flushIn};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string tag);
        chk({tag, ".selA0"}, 32'(ifA.fwdSel[1:0]), 32'(refSel(0)));
        chk({tag, ".selA1"}, 32'(ifA.fwdSel[3:2]), 32'(refSel(1)));
        chk({tag, ".selB0"}, 32'(ifB.fwdSel[1:0]), 32'(refSel(0)));
        chk({tag, ".selB1"}, 32'(ifB.fwdSel[3:2]), 32'(refSel(1)));
        chk({tag, ".ctlA"}, 32'({ifA.pcWrite, ifA.ifidWrite, ifA.idexWrite,
                                 ifA.bubbleID, ifA.bubbleEX, ifA.ifidFlush}), 32'(refCtl(1)));
        chk({tag, ".ctlB"}, 32'({ifB.pcWrite, ifB.ifidWrite, ifB.idexWrite,
                                 ifB.bubbleID, ifB.bubbleEX, ifB.ifidFlush}), 32'(refCtl(2)));
        chk({tag, ".busyA"}, 32'(ifA.mdBusy), 32'(mdRemain > 0));
        chk({tag, ".doneA"}, 32'(ifA.mdDone), 32'(mdRemain == 1));
        chk({tag, ".busyB"}, 32'(ifB.mdBusy), 32'(mdRemain > 0));
        chk({tag, ".doneB"}, 32'(ifB.mdDone), 32'(mdRemain == 1));
`ifdef HAZARD_PERF_EN
        chk({tag, ".ldCntA"}, ifA.loadStallCnt, 32'(ldCntA));
        chk({tag, ".ldCntB"}, ifB.loadStallCnt, 32'(ldCntB));
        chk({tag, ".mdCntA"}, ifA.mdStallCnt, 32'(mdCntM));
        chk({tag, ".mdCntB"}, ifB.mdStallCnt, 32'(mdCntM));
`endif
    endtask

    task automatic sample(string tag);
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic tick();
        @(posedge clk);
`ifdef HAZARD_PERF_EN
        if (!reset_n) begin
            ldCntA = 0; ldCntB = 0; mdCntM = 0;
        end else begin
            if (mdRemain > 0 && mdCntM < 64'hFFFF_FFFF) mdCntM++;
            if (mdRemain == 0 && refHaz(1) && ldCntA < 64'hFFFF_FFFF) ldCntA++;
            if (mdRemain == 0 && refHaz(2) && ldCntB < 64'hFFFF_FFFF) ldCntB++;
        end
`endif
        if (!reset_n)          mdRemain = 0;
        else if (mdRemain > 0) mdRemain--;
        else if (mdStart)      mdRemain = MD_LAT - 1;
        #1;
    endtask

    task automatic clearAll();
        stageEn = '0; stageLoad = '0; stageReg = '0;
        srcReg = '0; srcUsed = '0; mdStart = 1'b0; flushIn = 1'b0;
    endtask

    task automatic setStage(int k, bit en, bit ld, int r);
        stageEn[k-1]   = en;
        stageLoad[k-1] = ld;
        stageReg[(k-1)*REG_W +: REG_W] = REG_W'(r);
    endtask

    task automatic setSrc(int i, int r, bit used);
        srcReg[i*REG_W +: REG_W] = REG_W'(r);
        srcUsed[i] = used;
    endtask

    initial begin
        reset_n = 1'b0;
        clearAll();
        tick();
        sample("rst");
        chk("rst.pcWrite", 32'(ifA.pcWrite), 32'd1);
        chk("rst.idexWrite", 32'(ifA.idexWrite), 32'd1);
        tick();
        reset_n = 1'b1;

        // Forwarding priority and r0 exclusion
        setSrc(0, 5, 1'b1); setStage(1, 1'b1, 1'b0, 5); setStage(3, 1'b1, 1'b0, 5);
        sample("fwdPri"); chk("fwdPri.sel", 32'(ifA.fwdSel[1:0]), 32'd1); tick();
        setStage(1, 1'b0, 1'b0, 5);
        sample("fwdSkip"); chk("fwdSkip.sel", 32'(ifA.fwdSel[1:0]), 32'd3); tick();
        clearAll(); setSrc(0, 0, 1'b1); setStage(1, 1'b1, 1'b0, 0);
        sample("fwdR0"); chk("fwdR0.sel", 32'(ifA.fwdSel[1:0]), 32'd0); tick();

        // Load-use on used and unused source
        clearAll(); setStage(1, 1'b1, 1'b1, 7); setSrc(1, 7, 1'b1);
        sample("ldUse");
        chk("ldUse.pcWrite", 32'(ifA.pcWrite), 32'd0);
        chk("ldUse.ifidWrite", 32'(ifA.ifidWrite), 32'd0);
        chk("ldUse.bubbleID", 32'(ifA.bubbleID), 32'd1);
        tick();
        srcUsed[1] = 1'b0;
        sample("ldUnused"); chk("ldUnused.pcWrite", 32'(ifA.pcWrite), 32'd1); tick();

        // LOAD_LAT=2 instance sees stage-2 load as a hazard
        clearAll(); setStage(2, 1'b1, 1'b1, 3); setSrc(0, 3, 1'b1);
        sample("lat2");
        chk("lat2.pcWriteB", 32'(ifB.pcWrite), 32'd0);
        chk("lat2.pcWriteA", 32'(ifA.pcWrite), 32'd1);
        tick();
        clearAll(); setStage(3, 1'b1, 1'b1, 3); setSrc(0, 3, 1'b1);
        sample("lat2s3");
        chk("lat2s3.selB", 32'(ifB.fwdSel[1:0]), 32'd3);
        chk("lat2s3.pcWriteB", 32'(ifB.pcWrite), 32'd1);
        tick();

        // Flush gating
        clearAll(); setStage(1, 1'b1, 1'b1, 7); setSrc(1, 7, 1'b1); flushIn = 1'b1;
        sample("flushStall"); chk("flushStall.ifidFlush", 32'(ifA.ifidFlush), 32'd0); tick();
        clearAll(); flushIn = 1'b1;
        sample("flushRun"); chk("flushRun.ifidFlush", 32'(ifA.ifidFlush), 32'd1); tick();

        // Mul/div sequence; mdStart held high in busy to show it is ignored
        clearAll(); mdStart = 1'b1;
        sample("mdStart"); chk("mdStart.busy", 32'(ifA.mdBusy), 32'd0); tick();
        for (int b = 1; b <= MD_LAT - 1; b++) begin
            flushIn = 1'b1;
            sample("mdBusy");
            chk("mdBusy.busy", 32'(ifA.mdBusy), 32'd1);
            chk("mdBusy.done", 32'(ifA.mdDone), 32'(b == MD_LAT - 1));
            chk("mdBusy.ctl", 32'({ifA.pcWrite, ifA.ifidWrite, ifA.idexWrite,
                                   ifA.bubbleEX, ifA.ifidFlush}), 32'b00010);
            if (b == MD_LAT - 1) mdStart = 1'b0;
            tick();
        end
        sample("mdEnd"); chk("mdEnd.busy", 32'(ifA.mdBusy), 32'd0); tick();

        // Reset in the 2nd busy cycle aborts without mdDone
        clearAll(); mdStart = 1'b1;
        sample("rstMd0"); tick();
        mdStart = 1'b0;
        sample("rstMd1"); tick();
        reset_n = 1'b0;
        sample("rstMd2"); chk("rstMd2.done", 32'(ifA.mdDone), 32'd0); tick();
        reset_n = 1'b1;
        sample("rstMd3");
        chk("rstMd3.busy", 32'(ifA.mdBusy), 32'd0);
        chk("rstMd3.done", 32'(ifA.mdDone), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rstMd3.mdCnt", ifA.mdStallCnt, 32'd0);
`endif
        tick();

        // Load-use on the final busy cycle shows up on the next RUN cycle
        clearAll(); mdStart = 1'b1;
        sample("coin0"); tick();
        mdStart = 1'b0;
        sample("coin1"); tick();
        sample("coin2"); tick();
        setStage(1, 1'b1, 1'b1, 7); setSrc(1, 7, 1'b1);
        sample("coin3"); chk("coin3.bubbleID", 32'(ifA.bubbleID), 32'd0); tick();
        sample("coin4"); chk("coin4.bubbleID", 32'(ifA.bubbleID), 32'd1); tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            for (int k = 1; k <= FWD; k++)
                setStage(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 7)));
            for (int i = 0; i < NUM_SRC; i++)
                setSrc(i, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            mdStart = ($urandom_range(0, 7) == 0);
            flushIn = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 63) != 0);
            sample("rnd");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised pipeline hazard and forwarding controller for the MIPS core. It sits beside the ID stage. It computes per-source forwarding selects across a configurable number of downstream stages and detects load-use hazards for loads of configurable latency. It also sequences a multi-cycle stall for the mul/div unit in EX, and gates branch flushes against active stalls.

## Interface
Parameters:
- REG_W, 5, register-index width
- NUM_SRC, 2, number of ID-stage source operands checked
- FWD_STAGES, 3, downstream stages with result tags (stage 1 = EX, 2 = MEM, 3 = WB, ...)
- LOAD_LAT, 1, loads in stage k ≤ LOAD_LAT have no forwardable data; range 1..FWD_STAGES-1
- MD_LAT, 4, EX occupancy of a mul/div op in cycles; ≥ 2
- SEL_W, $clog2(FWD_STAGES+1), width of each forwarding select

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- stageEn  in  FWD_STAGES  register-file write enable per stage (bit k-1 = stage k)
- stageLoad  in  FWD_STAGES  stage holds a load
- stageReg  in  FWD_STAGES*REG_W  destination register per stage, stage 1 in LSBs
- srcReg  in  NUM_SRC*REG_W  source registers in ID, source 0 in LSBs
- srcUsed  in  NUM_SRC  source is actually read by the ID instruction
- mdStart  in  1  valid mul/div op in EX this cycle
- flushIn  in  1  branch/jump redirect request from ID
- fwdSel  out  NUM_SRC*SEL_W  per-source select: 0 = register file, k = stage k
- pcWrite  out  1  1 = PC/NPC advance
- ifidWrite  out  1  1 = IF/ID register loads
- idexWrite  out  1  1 = ID/EX register loads
- bubbleID  out  1  force NOP control into ID/EX
- bubbleEX  out  1  force NOP control into EX/MEM
- ifidFlush  out  1  clear IF/ID
- mdBusy  out  1  mul/div sequencer is active
- mdDone  out  1  one-cycle pulse on the last busy cycle

## Operation
- Forwarding, per source i: pick the lowest k with stageEn[k-1] and stageReg[k] == srcReg[i] and srcReg[i] != 0. If there is a match, fwdSel = k; otherwise 0. Register 0 never forwards.
- Load-use hazard: some used source i has its nearest match (as above) at a stage k with stageLoad[k-1]=1 and k ≤ LOAD_LAT. Unused sources (srcUsed=0) never stall.
- FSM states:
  - RUN → MD_BUSY when mdStart=1. Counter loads MD_LAT-1.
  - MD_BUSY: counter decrements each cycle. The cycle where the counter = 1 asserts mdDone. The next edge returns to RUN.
  - mdStart is ignored while in MD_BUSY.
- Output priority, highest first:
  1. MD_BUSY: pcWrite=0, ifidWrite=0, idexWrite=0, bubbleID=0, bubbleEX=1, ifidFlush=0.
  2. Load-use hazard in RUN: pcWrite=0, ifidWrite=0, idexWrite=1, bubbleID=1, bubbleEX=0, ifidFlush=0.
  3. Otherwise: all write enables 1, bubbles 0, ifidFlush = flushIn.
- flushIn is ignored while any stall is active. The ID branch re-presents it after the stall clears.
- fwdSel is always computed, including during stalls.

## Timing
- Forwarding and stall outputs are combinational from inputs and the registered FSM state. There is no added latency.
- FSM and counter update on the rising clk edge.
- mdBusy rises the cycle after mdStart is sampled in RUN. It stays high for MD_LAT-1 cycles; together with the mdStart cycle, EX is held MD_LAT cycles total.
- The mdStart cycle itself behaves as RUN: no stall from mul/div yet, but load-use rules apply.
- Reset (reset_n=0 at an edge):
  - FSM → RUN, counter → 0, mdBusy=0, mdDone=0.
  - A reset mid-MD_BUSY aborts the sequence with no mdDone pulse.
  - While reset is held, stall outputs follow RUN rules. Since no FSM stall exists, pcWrite=ifidWrite=idexWrite=1 with all-zero inputs.
- A load-use hazard coincident with the final MD_BUSY cycle is reported on the following RUN cycle.

## Configuration
- HAZARD_PERF_EN defined: adds two 32-bit saturating outputs, loadStallCnt and mdStallCnt.
  - loadStallCnt increments each cycle with a load-use stall.
  - mdStallCnt increments each cycle in MD_BUSY.
  - Both clear on reset and hold at 32'hFFFFFFFF.
- HAZARD_PERF_EN undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Forwarding priority (defaults): src0=5; stage1 and stage3 both write r5 → fwdSel[0]=1. Stage1 disabled → fwdSel[0]=3. src0=0 with stage1 writing r0 → fwdSel[0]=0.
- Load-use stall: stage1 load to r7, src1=r7 used → pcWrite=0, ifidWrite=0, bubbleID=1 for one cycle. Same stimulus with srcUsed[1]=0 → no stall.
- LOAD_LAT=2: load to r3 in stage 2, src0=r3 → stall. The load in stage 3 → fwdSel[0]=3, no stall.
- Mul/div: mdStart pulse with MD_LAT=4 → mdBusy high 3 cycles, bubbleEX=1 and all write enables 0 during those cycles, mdDone on the 3rd busy cycle, then RUN.
- Flush gating: flushIn=1 during a load stall → ifidFlush=0. flushIn=1 in a clean RUN cycle → ifidFlush=1.
- Reset mid-operation: reset_n=0 on the 2nd MD_BUSY cycle → next cycle mdBusy=0, no mdDone. With HAZARD_PERF_EN, mdStallCnt=0 after reset.
